// File: rtl/psr_bank.sv
// psr_bank: banked program-status registers for the execute stage.
//
// Holds the CPSR and one SPSR for each privileged exception mode. It also
// prioritises exception requests, arms each one on its edge, and performs
// SPSR->CPSR restore and MSR field-masked writes. MRS readback is
// combinational.
//
// Status register layout: [SR_W-1:8] flags, [7] I, [6] F, [5] T, [4:0] mode.
//
// Ports
//   clk         core clock
//   reset       asynchronous reset, active low
//   exc_req     level exception requests {FIQ,IRQ,UND,PABT,DABT,SWI}
//   flags_next  new condition flags, loaded when flag_en is set
//   flag_en     load flags_next into the CPSR flags
//   t_next      new Thumb bit, loaded when t_en is set
//   t_en        load t_next into CPSR.T
//   restore     exception return: CPSR <= SPSR of the current mode
//   wr_en       MSR write strobe
//   wr_spsr     MSR target: 0 = CPSR, 1 = current-mode SPSR
//   wr_mask     MSR field mask: [1] flags, [0] control (I,F,T,mode)
//   wr_data     MSR data
//   rd_spsr     MRS select: 0 = CPSR, 1 = current-mode SPSR
//   cpsr        current CPSR (registered)
//   rd_data     MRS data (combinational)
//   exc_taken   one-cycle pulse on exception entry
//   exc_vector  vector offset of the entered exception, valid with exc_taken
module psr_bank #(
    parameter int FLAG_W   = 4,
    parameter int NUM_EXC  = 6,
    parameter int NUM_BANK = 5,
    localparam int SR_W    = FLAG_W + 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EXC-1:0] exc_req,
    input  logic [FLAG_W-1:0]  flags_next,
    input  logic               flag_en,
    input  logic               t_next,
    input  logic               t_en,
    input  logic               restore,
    input  logic               wr_en,
    input  logic               wr_spsr,
    input  logic [1:0]         wr_mask,
    input  logic [SR_W-1:0]    wr_data,
    input  logic               rd_spsr,
    output logic [SR_W-1:0]    cpsr,
    output logic [SR_W-1:0]    rd_data,
    output logic               exc_taken,
    output logic [4:0]         exc_vector
);

    localparam int BANK_W = $clog2(NUM_BANK);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int BANK_SVC = 0;
    localparam int BANK_ABT = 1;
    localparam int BANK_UND = 2;
    localparam int BANK_IRQ = 3;
    localparam int BANK_FIQ = 4;

    // Bit position of each request line in exc_req.
    localparam int SRC_SWI  = 0;
    localparam int SRC_DABT = 1;
    localparam int SRC_PABT = 2;
    localparam int SRC_UND  = 3;
    localparam int SRC_IRQ  = 4;
    localparam int SRC_FIQ  = 5;

    localparam int I_BIT = 7;
    localparam int F_BIT = 6;
    localparam int T_BIT = 5;

    // Reset CPSR: flags 0, I=1, F=1, T=0, SVC mode.
    localparam logic [SR_W-1:0] CPSR_RST = {{FLAG_W{1'b0}}, 3'b110, MODE_SVC};

    typedef struct packed {
        logic              vld;
        logic [BANK_W-1:0] idx;
    } bank_sel_t;

    // Maps a mode to its SPSR bank. USR, SYS and unknown modes have no bank.
    function automatic bank_sel_t mode_bank(input logic [4:0] mode);
        bank_sel_t b;
        b.vld = 1'b1;
        b.idx = '0;
        case (mode)
            MODE_SVC: b.idx = BANK_W'(BANK_SVC);
            MODE_ABT: b.idx = BANK_W'(BANK_ABT);
            MODE_UND: b.idx = BANK_W'(BANK_UND);
            MODE_IRQ: b.idx = BANK_W'(BANK_IRQ);
            MODE_FIQ: b.idx = BANK_W'(BANK_FIQ);
            default:  b.vld = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic mode_legal(input logic [4:0] mode);
        return mode_bank(mode).vld || (mode == MODE_USR) || (mode == MODE_SYS);
    endfunction

    logic [SR_W-1:0]    cpsr_q, cpsr_d;
    logic [SR_W-1:0]    spsr_q [NUM_BANK];
    logic [SR_W-1:0]    spsr_d [NUM_BANK];
    logic [NUM_EXC-1:0] armed_q, armed_d;
    logic               exc_taken_q, exc_taken_d;
    logic [4:0]         exc_vector_q, exc_vector_d;

    logic [NUM_EXC-1:0] elig;
    logic [NUM_EXC-1:0] ent_onehot;
    logic               ent_vld;
    logic [4:0]         ent_mode;
    logic [4:0]         ent_vec;
    bank_sel_t          ent_bank;
    bank_sel_t          cur_bank;

    assign cur_bank = mode_bank(cpsr_q[4:0]);
    assign ent_bank = mode_bank(ent_mode);

    // Exception arbitration. IRQ and FIQ are masked by the current I/F bits.
    always_comb begin
        // NOTE: every signal gets a default before the priority chain, so no
        // path through this block leaves it unassigned and no latch is inferred.
        elig       = exc_req & armed_q;
        ent_onehot = '0;
        ent_vld    = 1'b1;
        ent_mode   = MODE_SVC;
        ent_vec    = 5'h00;
        if (cpsr_q[I_BIT]) elig[SRC_IRQ] = 1'b0;
        if (cpsr_q[F_BIT]) elig[SRC_FIQ] = 1'b0;

        if (elig[SRC_DABT]) begin
            ent_onehot[SRC_DABT] = 1'b1;
            ent_mode = MODE_ABT;
            ent_vec  = 5'h10;
        end else if (elig[SRC_FIQ]) begin
            ent_onehot[SRC_FIQ] = 1'b1;
            ent_mode = MODE_FIQ;
            ent_vec  = 5'h1C;
        end else if (elig[SRC_IRQ]) begin
            ent_onehot[SRC_IRQ] = 1'b1;
            ent_mode = MODE_IRQ;
            ent_vec  = 5'h18;
        end else if (elig[SRC_PABT]) begin
            ent_onehot[SRC_PABT] = 1'b1;
            ent_mode = MODE_ABT;
            ent_vec  = 5'h0C;
        end else if (elig[SRC_UND]) begin
            ent_onehot[SRC_UND] = 1'b1;
            ent_mode = MODE_UND;
            ent_vec  = 5'h04;
        end else if (elig[SRC_SWI]) begin
            ent_onehot[SRC_SWI] = 1'b1;
            ent_mode = MODE_SVC;
            ent_vec  = 5'h08;
        end else begin
            ent_vld = 1'b0;
        end
    end

    // Next-state logic. Only one update class wins per cycle:
    // entry > restore > MSR write > flag_en/t_en.
    always_comb begin
        cpsr_d       = cpsr_q;
        spsr_d       = spsr_q;
        exc_taken_d  = 1'b0;
        exc_vector_d = exc_vector_q;
        // A line re-arms once it is sampled low. The line that is taken
        // disarms, so a request held high enters only once.
        armed_d      = (armed_q | ~exc_req) & ~ent_onehot;

        if (ent_vld) begin
            spsr_d[ent_bank.idx] = cpsr_q;
            cpsr_d[4:0]          = ent_mode;
            cpsr_d[I_BIT]        = 1'b1;
            cpsr_d[T_BIT]        = 1'b0;
            if (ent_onehot[SRC_FIQ]) cpsr_d[F_BIT] = 1'b1;
            exc_taken_d          = 1'b1;
            exc_vector_d         = ent_vec;
        end else if (restore) begin
            if (cur_bank.vld) cpsr_d = spsr_q[cur_bank.idx];
        end else if (wr_en) begin
            if (wr_spsr) begin
                if (cur_bank.vld) begin
                    if (wr_mask[1]) spsr_d[cur_bank.idx][SR_W-1:8] = wr_data[SR_W-1:8];
                    if (wr_mask[0]) spsr_d[cur_bank.idx][7:0]      = wr_data[7:0];
                end
            end else begin
                if (wr_mask[1]) cpsr_d[SR_W-1:8] = wr_data[SR_W-1:8];
                // User mode cannot change the control field. An illegal
                // mode encoding leaves the mode alone but still updates I/F/T.
                if (wr_mask[0] && (cpsr_q[4:0] != MODE_USR)) begin
                    cpsr_d[7:5] = wr_data[7:5];
                    if (mode_legal(wr_data[4:0])) cpsr_d[4:0] = wr_data[4:0];
                end
            end
        end else begin
            if (flag_en) cpsr_d[SR_W-1:8] = flags_next;
            if (t_en)    cpsr_d[T_BIT]    = t_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpsr_q       <= CPSR_RST;
            // NOTE: the SPSR bank is architectural state that software may read
            // straight after reset, so each entry is cleared explicitly.
            for (int b = 0; b < NUM_BANK; b++) spsr_q[b] <= '0;
            armed_q      <= '1;
            exc_taken_q  <= 1'b0;
            exc_vector_q <= 5'h00;
        end else begin
            // NOTE: non-blocking assignments, so every register samples its
            // pre-edge neighbours. The entry SPSR save relies on this to see the old CPSR.
            cpsr_q       <= cpsr_d;
            spsr_q       <= spsr_d;
            armed_q      <= armed_d;
            exc_taken_q  <= exc_taken_d;
            exc_vector_q <= exc_vector_d;
        end
    end

    // MRS readback. An SPSR read from a mode with no bank returns zero.
    always_comb begin
        rd_data = cpsr_q;
        if (rd_spsr) rd_data = cur_bank.vld ? spsr_q[cur_bank.idx] : '0;
    end

    assign cpsr       = cpsr_q;
    assign exc_taken  = exc_taken_q;
    assign exc_vector = exc_vector_q;

endmodule

// File: tb/tb_psr_bank.sv
// Testbench for psr_bank. The stimulus process drives directed and random
// cycles and advances a rule-level reference model. Each expected exception
// entry goes into a queue. A separate monitor compares the DUT outputs against
// the model after every rising edge, and pops an entry from the queue
// whenever exc_taken is presented.
module tb_psr_bank;

    localparam int FLAG_W   = 4;
    localparam int NUM_EXC  = 6;
    localparam int NUM_BANK = 5;
    localparam int SR_W     = FLAG_W + 8;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_EXC-1:0] exc_req;
    logic [FLAG_W-1:0]  flags_next;
    logic               flag_en;
    logic               t_next;
    logic               t_en;
    logic               restore;
    logic               wr_en;
    logic               wr_spsr;
    logic [1:0]         wr_mask;
    logic [SR_W-1:0]    wr_data;
    logic               rd_spsr;
    logic [SR_W-1:0]    cpsr;
    logic [SR_W-1:0]    rd_data;
    logic               exc_taken;
    logic [4:0]         exc_vector;

    always #5 clk = ~clk;

    psr_bank #(.FLAG_W(FLAG_W), .NUM_EXC(NUM_EXC), .NUM_BANK(NUM_BANK)) dut (
        .clk(clk), .reset(reset), .exc_req(exc_req), .flags_next(flags_next),
        .flag_en(flag_en), .t_next(t_next), .t_en(t_en), .restore(restore),
        .wr_en(wr_en), .wr_spsr(wr_spsr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_spsr(rd_spsr), .cpsr(cpsr), .rd_data(rd_data),
        .exc_taken(exc_taken), .exc_vector(exc_vector)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]      vec;
        logic [SR_W-1:0] cpsr;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state.
    logic [SR_W-1:0]    m_cpsr;
    logic [SR_W-1:0]    m_spsr [NUM_BANK];
    bit   [NUM_EXC-1:0] m_armed;
    bit                 model_live = 1'b0;

    // Exception tables, indexed by request line {0:SWI,1:DABT,2:PABT,3:UND,4:IRQ,5:FIQ}.
    int         prio   [6] = '{1, 5, 4, 2, 3, 0};
    logic [4:0] vec_of [6] = '{5'h08, 5'h10, 5'h0C, 5'h04, 5'h18, 5'h1C};
    logic [4:0] tgt_of [6] = '{M_SVC, M_ABT, M_ABT, M_UND, M_IRQ, M_FIQ};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic int bank_of(input logic [4:0] mode);
        case (mode)
            M_SVC:   return 0;
            M_ABT:   return 1;
            M_UND:   return 2;
            M_IRQ:   return 3;
            M_FIQ:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input logic [4:0] mode);
        return (bank_of(mode) >= 0) || (mode == M_USR) || (mode == M_SYS);
    endfunction

    function automatic logic [SR_W-1:0] exp_rd(input logic sel);
        int b;
        b = bank_of(m_cpsr[4:0]);
        if (!sel) return m_cpsr;
        return (b >= 0) ? m_spsr[b] : '0;
    endfunction

    task automatic model_reset();
        m_cpsr  = {{FLAG_W{1'b0}}, 3'b110, M_SVC};
        for (int b = 0; b < NUM_BANK; b++) m_spsr[b] = '0;
        m_armed = '1;
    endtask

    // Apply one clock edge to the model, using the inputs currently driven.
    task automatic model_step();
        logic [SR_W-1:0] old;
        int   taken;
        int   b;
        exp_t e;
        old   = m_cpsr;
        taken = -1;
        b     = bank_of(old[4:0]);
        for (int k = 0; k < 6; k++) begin
            int s;
            bit ok;
            s  = prio[k];
            ok = exc_req[s] && m_armed[s];
            if (s == 4 && old[7]) ok = 1'b0;
            if (s == 5 && old[6]) ok = 1'b0;
            if (ok && taken < 0) taken = s;
        end
        for (int s = 0; s < NUM_EXC; s++) if (!exc_req[s]) m_armed[s] = 1'b1;

        if (taken >= 0) begin
            m_armed[taken] = 1'b0;
            m_spsr[bank_of(tgt_of[taken])] = old;
            m_cpsr[4:0] = tgt_of[taken];
            m_cpsr[7]   = 1'b1;
            m_cpsr[5]   = 1'b0;
            if (taken == 5) m_cpsr[6] = 1'b1;
            e.vec  = vec_of[taken];
            e.cpsr = m_cpsr;
            exp_q.push_back(e);
        end else if (restore) begin
            if (b >= 0) m_cpsr = m_spsr[b];
        end else if (wr_en) begin
            if (wr_spsr) begin
                if (b >= 0) begin
                    if (wr_mask[1]) m_spsr[b][SR_W-1:8] = wr_data[SR_W-1:8];
                    if (wr_mask[0]) m_spsr[b][7:0]      = wr_data[7:0];
                end
            end else begin
                if (wr_mask[1]) m_cpsr[SR_W-1:8] = wr_data[SR_W-1:8];
                if (wr_mask[0] && old[4:0] != M_USR) begin
                    m_cpsr[7:5] = wr_data[7:5];
                    if (legal(wr_data[4:0])) m_cpsr[4:0] = wr_data[4:0];
                end
            end
        end else begin
            if (flag_en) m_cpsr[SR_W-1:8] = flags_next;
            if (t_en)    m_cpsr[5]        = t_next;
        end
    endtask

    task automatic drive_idle();
        exc_req    = '0;
        flags_next = '0;
        flag_en    = 1'b0;
        t_next     = 1'b0;
        t_en       = 1'b0;
        restore    = 1'b0;
        wr_en      = 1'b0;
        wr_spsr    = 1'b0;
        wr_mask    = 2'b00;
        wr_data    = '0;
    endtask

    task automatic msr(input logic spsr, input logic [1:0] mask, input logic [SR_W-1:0] data);
        drive_idle();
        wr_en   = 1'b1;
        wr_spsr = spsr;
        wr_mask = mask;
        wr_data = data;
    endtask

    // Called on a falling edge after the inputs are driven. Advances the
    // model and returns on the next falling edge.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    // Monitor: compares outputs after each rising edge and consumes expected entries.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (model_live) begin
                check("cpsr", cpsr, m_cpsr);
                check("rd_data", rd_data, exp_rd(rd_spsr));
                if (exc_taken) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_entry @%0t: exc_taken=1 vector=0x%0h, expected no entry", $time, exc_vector);
                    end else begin
                        e = exp_q.pop_front();
                        check("exc_vector", exc_vector, e.vec);
                        check("entry_cpsr", cpsr, e.cpsr);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_entry @%0t: exc_taken=0, expected entry with vector 0x%0h", $time, e.vec);
                end
            end
        end
    end

    initial begin : stimulus
        int op;
        int b;
        drive_idle();
        rd_spsr = 1'b1;
        reset   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_cpsr", cpsr, 12'h0D3);
        check("reset_exc_taken", exc_taken, 1'b0);
        check("reset_exc_vector", exc_vector, 5'h00);
        check("reset_spsr_svc", rd_data, 12'h000);

        reset = 1'b1;
        model_live = 1'b1;

        // Test 1: a SWI held for 3 cycles enters once and saves the reset CPSR.
        exc_req = 6'b000001;
        repeat (3) step();
        drive_idle();
        step();
        check("t1_spsr_svc", rd_data, 12'h0D3);

        // Test 2: in USR with I=0, DABT beats IRQ. IRQ is then masked by I=1.
        msr(1'b0, 2'b01, 12'h010);
        step();
        drive_idle();
        exc_req = 6'b010010;
        step();
        step();
        check("t2_cpsr_abt", cpsr, 12'h097);
        check("t2_spsr_abt", rd_data, 12'h010);
        drive_idle();
        step();

        // Test 3: restore beats a same-cycle MSR. Restore in USR is ignored.
        msr(1'b0, 2'b01, 12'h012);
        step();
        msr(1'b1, 2'b11, 12'hA10);
        step();
        msr(1'b0, 2'b11, 12'h3D3);
        restore = 1'b1;
        step();
        check("t3_restore", cpsr, 12'hA10);
        drive_idle();
        restore = 1'b1;
        step();
        check("t3_restore_usr", cpsr, 12'hA10);

        // Test 4: USR writes only flags. SVC writes I/F/T but keeps the mode on an illegal encoding.
        msr(1'b0, 2'b11, 12'h5D3);
        step();
        check("t4_usr_msr", cpsr, 12'h510);
        drive_idle();
        exc_req = 6'b000001;
        step();
        drive_idle();
        step();
        msr(1'b0, 2'b01, 12'h0A5);
        step();
        check("t4_svc_msr", cpsr, 12'h5B3);

        // Test 5: FIQ held for 4 cycles enters once. It re-enters after a low cycle and clearing F.
        drive_idle();
        exc_req = 6'b100000;
        repeat (4) step();
        check("t5_fiq_entry", cpsr, 12'h5D1);
        drive_idle();
        step();
        msr(1'b0, 2'b01, 12'h011);
        step();
        drive_idle();
        exc_req = 6'b100000;
        step();
        step();
        check("t5_spsr_fiq", rd_data, 12'h511);
        drive_idle();
        step();

        // Random phase.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1)
                exc_req = NUM_EXC'($urandom & $urandom & $urandom);
            restore = 1'b0;
            wr_en   = 1'b0;
            flag_en = 1'b0;
            t_en    = 1'b0;
            rd_spsr = 1'($urandom);
            b  = bank_of(m_cpsr[4:0]);
            op = $urandom_range(0, 3);
            case (op)
                1: if (b >= 0 && legal(m_spsr[b][4:0])) restore = 1'b1;
                2: begin
                    wr_en   = 1'b1;
                    wr_spsr = 1'($urandom);
                    wr_mask = 2'($urandom);
                    wr_data = SR_W'($urandom);
                    if (wr_spsr) wr_data[4:0] = tgt_of[$urandom_range(0, 5)];
                end
                3: begin
                    flag_en    = 1'($urandom);
                    t_en       = 1'($urandom);
                    flags_next = FLAG_W'($urandom);
                    t_next     = 1'($urandom);
                end
                default: ;
            endcase
            step();
        end

        // Test 6: reset arrives in the same cycle as a UND request, which aborts the entry.
        drive_idle();
        step();
        exc_req = 6'b001000;
        #2;
        reset      = 1'b0;
        model_live = 1'b0;
        @(posedge clk);
        #1;
        exc_req = '0;
        @(negedge clk);
        check("t6_cpsr", cpsr, 12'h0D3);
        check("t6_exc_taken", exc_taken, 1'b0);
        reset = 1'b1;
        model_reset();
        model_live = 1'b1;
        msr(1'b0, 2'b01, 12'h0DB);
        rd_spsr = 1'b1;
        step();
        check("t6_spsr_und", rd_data, 12'h000);
        check("t6_und_mode", cpsr, 12'h0DB);
        drive_idle();
        step();
        step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
